move_button_conditioner: RTL and testbench
==========================================

Name: move_button_conditioner

Overview:
- Input-conditioning stage directly upstream of the sprite movement block.
- Takes four raw, active-low, bouncing push-buttons (up/down/left/right) and produces clean single-cycle move_* pulses.
- Processing per button: 2-flop synchronisation, debounce, press-edge detection and hold-to-repeat.
- Opposing directions are cancelled so the movement stage never sees contradictory requests.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required to accept a level change (20 ms at 50 MHz). Must be ≥1.
- REPEAT_DELAY, 25000000: cycles a button must stay pressed after acceptance before the first auto-repeat pulse. 0 disables auto-repeat.
- REPEAT_PERIOD, 10000000: cycles between successive auto-repeat pulses. Must be ≥1.
- CNT_W, 26: width of the debounce and hold counters. Must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- btn_n  input  4  raw buttons, 0 = pressed; bit0 up, bit1 down, bit2 left, bit3 right
- move_up  output  1  one-cycle move request
- move_down  output  1  one-cycle move request
- move_left  output  1  one-cycle move request
- move_right  output  1  one-cycle move request
- pressed  output  4  debounced level per button, 1 = pressed, same bit order as btn_n

Behaviour:
- Reset (rst=0, asynchronous):
  - sync flops = 1 (released); stable state = released.
  - All counters = 0; pressed = 4'b0000; all move_* = 0.
- Synchroniser: two flops per bit (s1, s2), inverted so that 1 = pressed.
- Debounce, per bit, independent:
  - s2 == stable: deb_cnt <= 0.
  - s2 != stable and deb_cnt < DEBOUNCE_CYCLES-1: deb_cnt increments.
  - s2 != stable and deb_cnt == DEBOUNCE_CYCLES-1: stable <= s2, deb_cnt <= 0.
  - Any bounce back before acceptance restarts the count from 0.
- pressed is the registered stable state.
- Timing: let edge 0 be the first edge at which s1 samples a press, with the button held continuously.
  - s2 = 1 after edge 1.
  - stable flips at edge DEBOUNCE_CYCLES+1.
  - The raw move pulse is registered at edge DEBOUNCE_CYCLES+2 and is high for exactly one cycle.
- Auto-repeat, per bit, while stable = pressed:
  - hold_cnt clears on the press-acceptance edge, then increments each cycle.
  - First repeat pulse: REPEAT_DELAY cycles after the initial pulse.
  - Later repeat pulses: every REPEAT_PERIOD cycles.
  - Repeat pulses are single-cycle.
  - With REPEAT_DELAY = 0, only the initial pulse is generated.
- Release: the release is debounced the same way. On acceptance, hold_cnt clears, no pulse is generated, and pressed falls.
- Opposing-pair cancellation, applied on raw pulses in the same cycle:
  - up & down both pulsing: both move_up and move_down are 0 that cycle.
  - left & right both pulsing: same rule.
  - Orthogonal pairs (e.g. up+right) pass through together.
- Outputs: move_* are registered; no combinational path from btn_n.
- Counter widths: counters saturate-free by construction (compared against parameters); no wrap-around is permitted within CNT_W.
- Reset mid-operation: all state clears immediately.
  - A button still held when rst releases is treated as a new press.
  - It must re-debounce and produce a fresh initial pulse at the same latency as above.
- Glitches shorter than DEBOUNCE_CYCLES on any bit produce no pulse and no change on pressed.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=10):
- Clean press: btn_n[0] 1→0 sampled at edge 0 and held 15 cycles → move_up=1 for exactly one cycle after edge 6; pressed[0]=1 from edge 5; no other move_* activity.
- Bounce rejection: btn_n[2] toggles 0/1 every 2 cycles for 30 cycles, then stays 1 → move_left never asserts; pressed[2] stays 0.
- Auto-repeat: hold btn_n[3]=0 for 60 cycles → move_right pulses after edges 6, 26, 36, 46 (plus 56 if still held), each one cycle wide; after release, pressed[3] falls 5 edges later with no pulse.
- Cancellation: btn_n[0] and btn_n[1] pressed on the same edge and held 10 cycles → move_up=move_down=0 throughout; pressed=4'b0011. Same test with bits 0 and 3 → move_up and move_right both pulse together.
- Reset mid-hold: hold btn_n[1]=0, pulse rst low for 2 cycles at cycle 15 → all outputs 0 immediately; move_down pulses again exactly 6 edges after the first post-reset sampling edge.
- Reset values: assert rst=0 with random btn_n → move_*=0, pressed=0 throughout reset.

Source files
------------

// File: rtl/move_button_conditioner.sv
// move_button_conditioner
//   Conditions four raw, active-low, bouncing push-buttons into clean
//   single-cycle move requests for the sprite movement stage. Each button
//   goes through a 2-flop synchroniser, a debounce counter, press-edge
//   detection and hold-to-repeat. Opposing directions that request a move
//   in the same cycle cancel each other.
//
// Ports
//   clk         system clock
//   rst         asynchronous, active-low reset
//   btn_n[3:0]  raw buttons, 0 = pressed (bit0 up, bit1 down, bit2 left, bit3 right)
//   move_up     one-cycle move request
//   move_down   one-cycle move request
//   move_left   one-cycle move request
//   move_right  one-cycle move request
//   pressed     debounced level per button, 1 = pressed, same bit order as btn_n
module move_button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000,
  parameter int unsigned CNT_W           = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_n,
  output logic       move_up,
  output logic       move_down,
  output logic       move_left,
  output logic       move_right,
  output logic [3:0] pressed
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_C  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(REPEAT_PERIOD);
  localparam bit               REP_EN   = (REPEAT_DELAY != 0);

  // Hold-to-repeat phase: waiting out the initial delay, then periodic.
  typedef enum logic {
    REP_DELAY,
    REP_PERIODIC
  } rep_e;

  logic [3:0]       s1_q, s1_d;
  logic [3:0]       s2_q, s2_d;
  logic [3:0]       stable_q, stable_d;
  logic [3:0]       press_evt_q, press_evt_d;
  logic [3:0]       move_q, move_d;
  logic [CNT_W-1:0] deb_cnt_q [4];
  logic [CNT_W-1:0] deb_cnt_d [4];
  logic [CNT_W-1:0] hold_cnt_q [4];
  logic [CNT_W-1:0] hold_cnt_d [4];
  rep_e             rep_q [4];
  rep_e             rep_d [4];

  logic [3:0] sync_pressed;
  logic [3:0] accept;
  logic [3:0] fire;
  logic [3:0] raw;

  assign sync_pressed = ~s2_q;

  always_comb begin
    s1_d        = btn_n;
    s2_d        = s1_q;
    stable_d    = stable_q;
    press_evt_d = '0;
    accept      = '0;
    fire        = '0;
    raw         = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      deb_cnt_d[i]  = deb_cnt_q[i];
      hold_cnt_d[i] = hold_cnt_q[i];
      rep_d[i]      = rep_q[i];

      // Debounce: a differing synchronised level must persist for
      // DEBOUNCE_CYCLES consecutive cycles; any bounce back restarts.
      if (sync_pressed[i] == stable_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DEB_LAST) begin
        accept[i]    = 1'b1;
        stable_d[i]  = sync_pressed[i];
        deb_cnt_d[i] = '0;
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
      end

      fire[i] = stable_q[i] && REP_EN &&
                (((rep_q[i] == REP_DELAY)    && (hold_cnt_q[i] == DELAY_C)) ||
                 ((rep_q[i] == REP_PERIODIC) && (hold_cnt_q[i] == PERIOD_C)));

      // The press event is captured one cycle after acceptance so the
      // initial pulse lands one edge after pressed rises.
      raw[i] = press_evt_q[i] | fire[i];

      // hold_cnt restarts at 1 on each repeat so it never exceeds
      // max(REPEAT_DELAY, REPEAT_PERIOD) and cannot wrap.
      if (accept[i]) begin
        press_evt_d[i] = sync_pressed[i];
        hold_cnt_d[i]  = '0;
        rep_d[i]       = REP_DELAY;
      end else if (stable_q[i] && REP_EN) begin
        if (fire[i]) begin
          hold_cnt_d[i] = CNT_W'(1);
          rep_d[i]      = REP_PERIODIC;
        end else begin
          hold_cnt_d[i] = hold_cnt_q[i] + 1'b1;
        end
      end
    end

    move_d = raw;
    if (raw[0] && raw[1]) begin
      move_d[1:0] = 2'b00;
    end
    if (raw[2] && raw[3]) begin
      move_d[3:2] = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q        <= '1;
      s2_q        <= '1;
      stable_q    <= '0;
      press_evt_q <= '0;
      move_q      <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        deb_cnt_q[i]  <= '0;
        hold_cnt_q[i] <= '0;
        rep_q[i]      <= REP_DELAY;
      end
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      stable_q    <= stable_d;
      press_evt_q <= press_evt_d;
      move_q      <= move_d;
      for (int unsigned i = 0; i < 4; i++) begin
        deb_cnt_q[i]  <= deb_cnt_d[i];
        hold_cnt_q[i] <= hold_cnt_d[i];
        rep_q[i]      <= rep_d[i];
      end
    end
  end

  assign move_up    = move_q[0];
  assign move_down  = move_q[1];
  assign move_left  = move_q[2];
  assign move_right = move_q[3];
  assign pressed    = stable_q;

endmodule

// File: tb/tb_move_button_conditioner.sv
// Bench for move_button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_PERIOD=10. Scenario tasks push expected move pulses (cycle and
// vector) into a queue when they drive buttons; a monitor pops and compares
// them as the DUT produces pulses. Tasks also check pressed inline.
module tb_move_button_conditioner;

  localparam int DEB    = 4;
  localparam int DELAY  = 20;
  localparam int PERIOD = 10;

  logic       clk;
  logic       rst;
  logic [3:0] btn_n;
  logic       move_up, move_down, move_left, move_right;
  logic [3:0] pressed;

  move_button_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (DELAY),
    .REPEAT_PERIOD  (PERIOD),
    .CNT_W          (26)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_n     (btn_n),
    .move_up   (move_up),
    .move_down (move_down),
    .move_left (move_left),
    .move_right(move_right),
    .pressed   (pressed)
  );

  typedef struct {
    int         cyc;
    logic [3:0] vec;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   tests_run = 0;
  int   fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every nonzero move vector must match the queue head.
  always @(negedge clk) begin
    logic [3:0] obs;
    obs = {move_right, move_left, move_down, move_up};
    while (q.size() > 0 && q[0].cyc < cyc) begin
      tests_run++;
      fails++;
      $display("FAIL pulse_missing cyc=%0d got=none required=%b", q[0].cyc, q[0].vec);
      void'(q.pop_front());
    end
    if (obs !== 4'b0000) begin
      tests_run++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL pulse_unexpected cyc=%0d got=%b required=none", cyc, obs);
      end else if (q[0].cyc != cyc || q[0].vec !== obs) begin
        fails++;
        $display("FAIL pulse_match cyc=%0d got=%b required=%b@%0d", cyc, obs, q[0].vec, q[0].cyc);
      end
      if (q.size() > 0 && q[0].cyc == cyc) void'(q.pop_front());
    end
  end

  function automatic logic [3:0] cancel(input logic [3:0] m);
    logic [3:0] r;
    r = m;
    if (m[0] && m[1]) r[1:0] = 2'b00;
    if (m[2] && m[3]) r[3:2] = 2'b00;
    return r;
  endfunction

  // Called right after a negedge: press 'mask' held for h cycles, then release.
  // Edge e0 (next posedge) is the first sampling edge; initial pulse visible
  // after e0+6, pressed high for cycles [e0+5, e0+h+5).
  task automatic run_press(input logic [3:0] mask, input int h, input string name);
    int e0;
    logic [3:0] exp_p;
    btn_n = ~mask;
    e0 = cyc + 1;
    if (h >= DEB && cancel(mask) != 4'b0000) begin
      q.push_back('{e0 + DEB + 2, cancel(mask)});
      if (DELAY > 0)
        for (int p = DEB + 2 + DELAY; p <= h + DEB + 1; p += PERIOD)
          q.push_back('{e0 + p, cancel(mask)});
    end
    for (int k = 0; k < h + 10; k++) begin
      @(negedge clk);
      exp_p = (h >= DEB && k >= DEB + 1 && k < h + DEB + 1) ? mask : 4'b0000;
      tests_run++;
      if (pressed !== exp_p) begin
        fails++;
        $display("FAIL %s_pressed k=%0d got=%b required=%b", name, k, pressed, exp_p);
      end
      if (k == h - 1) btn_n = 4'hF;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tests_run++;
      if ({move_right, move_left, move_down, move_up} !== 4'b0000 || pressed !== 4'b0000) begin
        fails++;
        $display("FAIL reset_values got=%b/%b required=0000/0000",
                 {move_right, move_left, move_down, move_up}, pressed);
      end
      btn_n = 4'($urandom);
    end
    @(negedge clk);
    btn_n = 4'hF;
    rst   = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_clean_press();
    run_press(4'b0001, 15, "clean");
  endtask

  task automatic test_min_press();
    run_press(4'b0100, DEB, "min_press");
  endtask

  task automatic test_glitch();
    run_press(4'b0010, DEB - 1, "glitch");
  endtask

  task automatic test_bounce();
    for (int k = 0; k < 40; k++) begin
      btn_n = (k < 30) ? {1'b1, ~k[1], 2'b11} : 4'hF;
      @(negedge clk);
      tests_run++;
      if (pressed !== 4'b0000) begin
        fails++;
        $display("FAIL bounce_pressed k=%0d got=%b required=0000", k, pressed);
      end
    end
  endtask

  task automatic test_auto_repeat();
    run_press(4'b1000, 60, "repeat");
  endtask

  task automatic test_cancel();
    run_press(4'b0011, 10, "cancel_ud");
    run_press(4'b1100, 30, "cancel_lr");
    run_press(4'b1001, 10, "ortho_ur");
  endtask

  task automatic test_reset_mid_hold();
    int e0;
    btn_n = 4'b1101;
    e0 = cyc + 1;
    q.push_back('{e0 + DEB + 2, 4'b0010});
    repeat (15) @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++;
    if ({move_right, move_left, move_down, move_up} !== 4'b0000 || pressed !== 4'b0000) begin
      fails++;
      $display("FAIL reset_immediate got=%b/%b required=0000/0000",
               {move_right, move_left, move_down, move_up}, pressed);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run_press(4'b0010, 12, "post_reset");
  endtask

  initial begin
    rst   = 1'b0;
    btn_n = 4'hF;
    test_reset();
    test_clean_press();
    test_min_press();
    test_glitch();
    test_bounce();
    test_auto_repeat();
    test_cancel();
    test_reset_mid_hold();
    repeat (5) @(negedge clk);
    tests_run++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL queue_drained got=%0d required=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
